trace_reg_arbiter: RTL and testbench
====================================

Name: trace_reg_arbiter

Overview:
Shares the trace register bus (8-bit address, byte count, read/write strobes, addrvalid) between two masters. M0 is the USB register front end, which cannot be stalled. M1 is an on-chip configuration sequencer, for example the pattern/mask autoloader or the resync issuer, which issues atomic multi-byte bursts through a req/gnt handshake. The block sits between the USB front end and the trace register block, drives the single shared bus, and routes the registered read data (one-cycle latency) back to whichever master issued the read.

Parameters:
pBYTECNT_SIZE, 7, width of the byte counter on the bus and of m1_len.
pM1_TIMEOUT, 1024, M1 starvation threshold in cycles; used only with the optional feature.

Ports:
usb_clk  in  1  single clock.
reset_n  in  1  asynchronous, active-low reset.
m0_address  in  8  M0 register address.
m0_bytecnt  in  pBYTECNT_SIZE  M0 byte count.
m0_write_data  in  8  M0 write byte.
m0_read  in  1  M0 read strobe.
m0_write  in  1  M0 write strobe.
m0_addrvalid  in  1  M0 address valid.
m0_read_data  out  8  read data returned to M0.
m1_req  in  1  M1 burst request, level.
m1_address  in  8  M1 burst address; sampled at grant.
m1_len  in  pBYTECNT_SIZE  M1 burst byte count; sampled at grant.
m1_rnw  in  1  M1 burst direction, 1 = read; sampled at grant.
m1_wdata  in  8  current M1 write byte.
m1_wpop  out  1  M1 write byte consumed this cycle.
m1_gnt  out  1  high while M1 owns the bus.
m1_rdata  out  8  M1 read byte.
m1_rvalid  out  1  m1_rdata valid.
m1_done  out  1  one-cycle pulse: burst completed.
m1_abort  out  1  one-cycle pulse: burst preempted by M0.
reg_address  out  8  shared bus address.
reg_bytecnt  out  pBYTECNT_SIZE  shared bus byte count.
write_data  out  8  shared bus write byte.
reg_read  out  1  shared bus read strobe.
reg_write  out  1  shared bus write strobe.
reg_addrvalid  out  1  shared bus address valid.
read_data  in  8  registered read data from the register block, valid one cycle after reg_read.
O_m1_starved  out  1  sticky starvation flag; present only with the optional feature.

Behaviour:
- Reset: state IDLE. All outputs are 0, including the muxed bus outputs, m0_read_data and m1_rdata.
- States: IDLE, M0_OWN, M1_SETUP, M1_XFER, M1_DRAIN, GUARD.
- Bus mux is combinational from the state:
  - In M0_OWN, and in IDLE while m0_addrvalid=1, the bus carries the M0 inputs directly (zero-latency passthrough).
  - In M1 states the bus carries M1 values.
  - Otherwise all bus outputs are 0.
- IDLE:
  - m0_addrvalid=1 → M0_OWN. M0 always wins a simultaneous request.
  - Otherwise m1_req=1 → M1_SETUP with m1_gnt=1. m1_address, m1_len and m1_rnw are latched; the internal byte counter is cleared.
- M0_OWN: stays while m0_addrvalid=1, then → GUARD.
- M1_SETUP:
  - One cycle with reg_addrvalid=1 and no strobe.
  - Next state is M1_XFER, or M1_DRAIN if the latched len=0.
- M1_XFER:
  - Each cycle: reg_bytecnt = counter, one strobe (reg_read or reg_write), counter +1.
  - For writes, write_data = m1_wdata and m1_wpop=1 in the same cycle.
  - After the strobe with counter = len-1 → M1_DRAIN.
- M1_DRAIN: one cycle, reg_addrvalid=1, no strobe (this collects the last read byte). Then → GUARD with m1_done=1 in that cycle and m1_gnt dropping.
- GUARD: one cycle with all bus outputs 0 → IDLE. This guarantees an addrvalid gap between owners.
- Preemption:
  - m0_addrvalid=1 in any M1 state → M0_OWN next cycle, with m1_abort=1 and m1_gnt=0 in that cycle.
  - The M1 strobe in the preempting cycle still completes. Its read byte is still delivered to M1 with m1_rvalid.
  - M0 inputs reach the bus from the following cycle. M0 loses at most its first addrvalid cycle; the front end never strobes in its first addrvalid cycle.
- Read routing: a one-bit owner tag is registered with each reg_read.
  - Next cycle, read_data goes to m0_read_data (tag M0) or to m1_rdata with m1_rvalid=1 (tag M1).
  - The output that is not addressed is held at 0.
- m1_done and m1_abort are never asserted together. m1_req dropping mid-burst is ignored.
- Asynchronous reset mid-burst: immediate return to IDLE; no done or abort pulse.

Optional Feature:
- TRACE_ARB_TIMEOUT_EN defined:
  - A counter increments while m1_req=1 and m1_gnt=0, saturating at pM1_TIMEOUT.
  - Reaching pM1_TIMEOUT sets O_m1_starved sticky. Only reset clears it.
  - The counter clears on m1_gnt.
- Undefined: no counter and no O_m1_starved port. Arbitration is identical in both builds.

Test Plan:
- M1 write burst: m1_address=0x0E, len=8, m1_wdata 0x10..0x17 → reg_write on 8 consecutive cycles after setup, bytecnt 0..7, 8 m1_wpop pulses, m1_done 2 cycles after the last strobe.
- M1 read burst: addr=0x00, len=8, register block returns 0x41,0x72,... → 8 m1_rvalid bytes in order, m0_read_data stays 0.
- Simultaneous m0_addrvalid and m1_req in IDLE → M0 passthrough in the same cycle; M1 granted only after M0 releases plus 1 GUARD cycle.
- m0_addrvalid rises at M1 byte 3 of 8 → m1_abort pulse, no m1_done, M0 on the bus next cycle, byte 3 read still delivered to M1.
- len=0 → setup, drain and done with zero strobes. Assert reset_n low mid-XFER → bus outputs 0 immediately, no done.
- With TRACE_ARB_TIMEOUT_EN and pM1_TIMEOUT=16: hold M0 for 20 cycles with m1_req high → O_m1_starved=1 from cycle 16 and it stays set after the grant.

Source files
------------

// File: rtl/trace_reg_arbiter.sv
// ============================================================================
// trace_reg_arbiter
// ----------------------------------------------------------------------------
// Shares the trace register bus between two masters:
//   M0 - USB register front end. It cannot be stalled, so it always wins and
//        may preempt an M1 burst at any point.
//   M1 - on-chip configuration sequencer (pattern/mask autoloader, resync
//        issuer) issuing atomic multi-byte bursts through m1_req/m1_gnt.
// The block drives the single shared bus and routes the registered read data
// (one cycle of latency) back to whichever master issued the read.
//
// Optional feature (compile-time macro TRACE_ARB_TIMEOUT_EN):
//   When defined, a starvation counter runs while M1 requests without a grant
//   and a sticky O_m1_starved flag is raised once it reaches pM1_TIMEOUT.
//   When undefined, the counter and the O_m1_starved port do not exist.
//   Arbitration is identical in both builds.
//
// Parameters:
//   pBYTECNT_SIZE  width of the bus byte counter and of m1_len
//   pM1_TIMEOUT    M1 starvation threshold in cycles (optional feature only)
//
// Ports:
//   usb_clk, reset_n                     clock, asynchronous active-low reset
//   m0_address/bytecnt/write_data        M0 bus request fields
//   m0_read/m0_write/m0_addrvalid        M0 strobes and address valid
//   m0_read_data                         read byte returned to M0
//   m1_req                               M1 burst request (level)
//   m1_address/m1_len/m1_rnw             M1 burst descriptor, sampled at grant
//   m1_wdata, m1_wpop                    M1 write byte and its consume strobe
//   m1_gnt                               M1 owns the bus
//   m1_rdata, m1_rvalid                  M1 read byte and its valid
//   m1_done, m1_abort                    burst completed / burst preempted
//   reg_address/bytecnt/write_data       shared bus fields
//   reg_read/reg_write/reg_addrvalid     shared bus strobes and address valid
//   read_data                            registered read data from reg block
//   O_m1_starved                         sticky starvation flag (optional)
// ============================================================================
module trace_reg_arbiter #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pM1_TIMEOUT   = 1024
) (
    input  logic                     usb_clk,
    input  logic                     reset_n,

    input  logic [7:0]               m0_address,
    input  logic [pBYTECNT_SIZE-1:0] m0_bytecnt,
    input  logic [7:0]               m0_write_data,
    input  logic                     m0_read,
    input  logic                     m0_write,
    input  logic                     m0_addrvalid,
    output logic [7:0]               m0_read_data,

    input  logic                     m1_req,
    input  logic [7:0]               m1_address,
    input  logic [pBYTECNT_SIZE-1:0] m1_len,
    input  logic                     m1_rnw,
    input  logic [7:0]               m1_wdata,
    output logic                     m1_wpop,
    output logic                     m1_gnt,
    output logic [7:0]               m1_rdata,
    output logic                     m1_rvalid,
    output logic                     m1_done,
    output logic                     m1_abort,

    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               write_data,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic                     reg_addrvalid,
    input  logic [7:0]               read_data
`ifdef TRACE_ARB_TIMEOUT_EN
    ,
    output logic                     O_m1_starved
`endif
);

    // Elaboration-time parameter sanity checks.
    generate
        if (pBYTECNT_SIZE < 1) begin : g_bad_bytecnt_size
            $error("trace_reg_arbiter: pBYTECNT_SIZE must be at least 1");
        end
        if (pM1_TIMEOUT < 2) begin : g_bad_timeout
            $error("trace_reg_arbiter: pM1_TIMEOUT must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        M0_OWN,
        M1_SETUP,
        M1_XFER,
        M1_DRAIN,
        GUARD
    } state_t;

    localparam logic [pBYTECNT_SIZE-1:0] CNT_ONE = pBYTECNT_SIZE'(1);

    state_t                     state_q;
    state_t                     state_d;

    // Burst descriptor captured at grant; M1 may change its inputs afterwards.
    logic [7:0]                 addr_q;
    logic [pBYTECNT_SIZE-1:0]   len_q;
    logic                       rnw_q;
    logic [pBYTECNT_SIZE-1:0]   cnt_q;

    logic                       done_q;
    logic                       abort_q;

    // Owner tag travelling alongside each read strobe.
    logic                       rd_pend_q;
    logic                       rd_m1_q;

    logic                       m1_own;
    logic                       m0_pass;
    logic                       grant_m1;
    logic                       last_byte;

    assign m1_own    = (state_q == M1_SETUP) || (state_q == M1_XFER) ||
                       (state_q == M1_DRAIN);

    // M0 is passed through with zero latency as soon as it raises addrvalid
    // in IDLE, so the front end never sees a stall when the bus is free.
    assign m0_pass   = (state_q == M0_OWN) ||
                       ((state_q == IDLE) && m0_addrvalid);

    assign grant_m1  = (state_q == IDLE) && !m0_addrvalid && m1_req;

    // Only evaluated in M1_XFER, which is never entered with len_q == 0.
    assign last_byte = (cnt_q == (len_q - CNT_ONE));

    // State register.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. M0 addrvalid preempts every M1 state; the M1 strobe
    // of the preempting cycle still goes out because the bus mux looks only
    // at the current state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_addrvalid) begin
                    state_d = M0_OWN;
                end else if (m1_req) begin
                    state_d = M1_SETUP;
                end
            end
            M0_OWN: begin
                if (!m0_addrvalid) begin
                    state_d = GUARD;
                end
            end
            M1_SETUP: begin
                if (m0_addrvalid) begin
                    state_d = M0_OWN;
                end else if (len_q == '0) begin
                    state_d = M1_DRAIN;
                end else begin
                    state_d = M1_XFER;
                end
            end
            M1_XFER: begin
                if (m0_addrvalid) begin
                    state_d = M0_OWN;
                end else if (last_byte) begin
                    state_d = M1_DRAIN;
                end
            end
            M1_DRAIN: begin
                if (m0_addrvalid) begin
                    state_d = M0_OWN;
                end else begin
                    state_d = GUARD;
                end
            end
            GUARD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Burst descriptor capture and byte counter.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= 8'h00;
            len_q  <= '0;
            rnw_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (grant_m1) begin
            addr_q <= m1_address;
            len_q  <= m1_len;
            rnw_q  <= m1_rnw;
            cnt_q  <= '0;
        end else if (state_q == M1_XFER) begin
            cnt_q  <= cnt_q + CNT_ONE;
        end
    end

    // Completion and preemption pulses appear in the cycle after the decision
    // (first GUARD cycle or first M0_OWN cycle). Both are decided in mutually
    // exclusive conditions, so they can never be high together, and an
    // asynchronous reset clears them without producing a pulse.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= (state_q == M1_DRAIN) && !m0_addrvalid;
            abort_q <= m1_own && m0_addrvalid;
        end
    end

    // Read owner tag: remembers who issued the strobe so the returning byte
    // (valid one cycle later) is steered to the right master.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q <= 1'b0;
            rd_m1_q   <= 1'b0;
        end else begin
            rd_pend_q <= reg_read;
            rd_m1_q   <= m1_own;
        end
    end

    // Shared bus mux, combinational from the state. GUARD and IDLE without
    // M0 addrvalid leave the bus at zero, which creates the addrvalid gap
    // between owners.
    always_comb begin
        reg_address   = 8'h00;
        reg_bytecnt   = '0;
        write_data    = 8'h00;
        reg_read      = 1'b0;
        reg_write     = 1'b0;
        reg_addrvalid = 1'b0;
        m1_wpop       = 1'b0;
        if (m0_pass) begin
            reg_address   = m0_address;
            reg_bytecnt   = m0_bytecnt;
            write_data    = m0_write_data;
            reg_read      = m0_read;
            reg_write     = m0_write;
            reg_addrvalid = m0_addrvalid;
        end else if (m1_own) begin
            reg_address   = addr_q;
            reg_bytecnt   = cnt_q;
            reg_addrvalid = 1'b1;
            if (state_q == M1_XFER) begin
                reg_read   = rnw_q;
                reg_write  = ~rnw_q;
                m1_wpop    = ~rnw_q;
                write_data = rnw_q ? 8'h00 : m1_wdata;
            end
        end
    end

    // Master-side outputs. The read port that is not addressed stays at zero.
    always_comb begin
        m1_gnt       = m1_own;
        m1_done      = done_q;
        m1_abort     = abort_q;
        m1_rvalid    = rd_pend_q && rd_m1_q;
        m1_rdata     = (rd_pend_q && rd_m1_q)  ? read_data : 8'h00;
        m0_read_data = (rd_pend_q && !rd_m1_q) ? read_data : 8'h00;
    end

`ifdef TRACE_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(pM1_TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt_q;
    logic            starved_q;

    // Starvation monitor: counts cycles M1 waits without a grant, saturating
    // at the threshold. The flag is set on the edge the counter reaches the
    // threshold and stays set until reset, even after M1 is granted.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
            starved_q  <= 1'b0;
        end else if (m1_gnt) begin
            wait_cnt_q <= '0;
        end else if (m1_req && (wait_cnt_q != TO_W'(pM1_TIMEOUT))) begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
            if (wait_cnt_q == TO_W'(pM1_TIMEOUT - 1)) begin
                starved_q <= 1'b1;
            end
        end
    end

    assign O_m1_starved = starved_q;
`endif

endmodule

// File: tb/tb_trace_reg_arbiter.sv
// ============================================================================
// tb_trace_reg_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for trace_reg_arbiter. A small register-block model
// answers reads one cycle after reg_read with a value computed from the
// address and byte count. Each scenario task builds its expected cycle
// timeline from the arbitration rules (setup, transfer bytes, drain, guard,
// preemption) and compares the DUT outputs at the falling clock edge.
// Define TRACE_ARB_TIMEOUT_EN to also exercise the starvation flag.
// ============================================================================
module tb_trace_reg_arbiter;

    localparam int BW = 7;

    logic          usb_clk = 1'b0;
    logic          reset_n;

    logic [7:0]    m0_address;
    logic [BW-1:0] m0_bytecnt;
    logic [7:0]    m0_write_data;
    logic          m0_read;
    logic          m0_write;
    logic          m0_addrvalid;
    logic [7:0]    m0_read_data;

    logic          m1_req;
    logic [7:0]    m1_address;
    logic [BW-1:0] m1_len;
    logic          m1_rnw;
    logic [7:0]    m1_wdata;
    logic          m1_wpop;
    logic          m1_gnt;
    logic [7:0]    m1_rdata;
    logic          m1_rvalid;
    logic          m1_done;
    logic          m1_abort;

    logic [7:0]    reg_address;
    logic [BW-1:0] reg_bytecnt;
    logic [7:0]    write_data;
    logic          reg_read;
    logic          reg_write;
    logic          reg_addrvalid;
    logic [7:0]    read_data;
`ifdef TRACE_ARB_TIMEOUT_EN
    logic          O_m1_starved;
`endif

    int            vectors;
    int            miscompares;
    logic [7:0]    salt;

    trace_reg_arbiter #(
        .pBYTECNT_SIZE (BW),
        .pM1_TIMEOUT   (16)
    ) dut (
        .usb_clk       (usb_clk),
        .reset_n       (reset_n),
        .m0_address    (m0_address),
        .m0_bytecnt    (m0_bytecnt),
        .m0_write_data (m0_write_data),
        .m0_read       (m0_read),
        .m0_write      (m0_write),
        .m0_addrvalid  (m0_addrvalid),
        .m0_read_data  (m0_read_data),
        .m1_req        (m1_req),
        .m1_address    (m1_address),
        .m1_len        (m1_len),
        .m1_rnw        (m1_rnw),
        .m1_wdata      (m1_wdata),
        .m1_wpop       (m1_wpop),
        .m1_gnt        (m1_gnt),
        .m1_rdata      (m1_rdata),
        .m1_rvalid     (m1_rvalid),
        .m1_done       (m1_done),
        .m1_abort      (m1_abort),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .write_data    (write_data),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .reg_addrvalid (reg_addrvalid),
        .read_data     (read_data)
`ifdef TRACE_ARB_TIMEOUT_EN
        ,
        .O_m1_starved  (O_m1_starved)
`endif
    );

    always #5 usb_clk = ~usb_clk;

    // Contents of the modelled register file.
    function automatic logic [7:0] reg_value(input logic [7:0] a, input logic [BW-1:0] b);
        return 8'((a * 7) + (b * 8'h31) + salt);
    endfunction

    // Register block model: registered read data, one cycle after reg_read.
    always @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data <= 8'h00;
        end else begin
            read_data <= reg_read ? reg_value(reg_address, reg_bytecnt) : 8'h00;
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] bus_flags();
        return {m1_gnt, reg_addrvalid, reg_read, reg_write,
                m1_wpop, m1_done, m1_abort, m1_rvalid};
    endfunction

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge usb_clk);
    endtask

    task automatic idle_inputs();
        m0_address    = 8'h00;
        m0_bytecnt    = '0;
        m0_write_data = 8'h00;
        m0_read       = 1'b0;
        m0_write      = 1'b0;
        m0_addrvalid  = 1'b0;
        m1_req        = 1'b0;
        m1_address    = 8'h00;
        m1_len        = '0;
        m1_rnw        = 1'b0;
        m1_wdata      = 8'h00;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) sample();
        vectors++;
        if (bus_flags() !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %h expected 00", bus_flags());
        end
        vectors++;
        if ({reg_address, reg_bytecnt, write_data} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_bus: got %h/%h/%h expected zero", reg_address, reg_bytecnt, write_data);
        end
        vectors++;
        if ({m0_read_data, m1_rdata} !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_rdata: got %h/%h expected 0000", m0_read_data, m1_rdata);
        end
        tick();
        reset_n = 1'b1;
        sample();
        vectors++;
        if (bus_flags() !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL post_reset_flags: got %h expected 00", bus_flags());
        end
    endtask

    // ------------------------------------------------------------------
    // One M1 burst with no M0 activity. Timeline after the request cycle:
    // setup, len transfer cycles, drain, guard (done pulse), then idle.
    task automatic test_burst(input logic [7:0] addr, input int len, input bit rnw,
                              input bit fixed_data, input logic [7:0] wbase);
        logic [7:0] wq[$];
        int         popped;
        bit         xfer, rv_e;
        logic [7:0] exp_flags, exp_wd, exp_rd;
        for (int i = 0; i < len; i++) begin
            wq.push_back(fixed_data ? 8'(wbase + 8'(i)) : 8'($urandom));
        end
        popped = 0;
        tick();
        m1_req     = 1'b1;
        m1_address = addr;
        m1_len     = BW'(len);
        m1_rnw     = rnw;
        m1_wdata   = (len > 0) ? wq[0] : 8'h00;
        sample();
        vectors++;
        if (bus_flags() !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL burst_req_cycle: got %h expected 00", bus_flags());
        end
        for (int c = 0; c <= len + 2; c++) begin
            tick();
            // Descriptor inputs are scrambled after grant; the burst must not follow them.
            m1_req     = 1'b0;
            m1_address = 8'($urandom);
            m1_len     = BW'($urandom);
            m1_rnw     = ~rnw;
            m1_wdata   = (popped < len) ? wq[popped] : 8'h00;
            sample();
            xfer      = (c >= 1) && (c <= len);
            rv_e      = rnw && (c >= 2) && (c <= len + 1);
            exp_flags = {(c <= len + 1), (c <= len + 1), xfer && rnw, xfer && !rnw,
                         xfer && !rnw, (c == len + 2), 1'b0, rv_e};
            exp_wd    = (xfer && !rnw) ? wq[c-1] : 8'h00;
            exp_rd    = rv_e ? reg_value(addr, BW'(c - 2)) : 8'h00;
            vectors++;
            if (bus_flags() !== exp_flags) begin
                miscompares++;
                $display("[TB] FAIL burst_flags c=%0d len=%0d rnw=%0d: got %h expected %h", c, len, rnw, bus_flags(), exp_flags);
            end
            vectors++;
            if (reg_address !== ((c <= len + 1) ? addr : 8'h00)) begin
                miscompares++;
                $display("[TB] FAIL burst_address c=%0d: got %h expected %h", c, reg_address, (c <= len + 1) ? addr : 8'h00);
            end
            if (xfer) begin
                vectors++;
                if (reg_bytecnt !== BW'(c - 1)) begin
                    miscompares++;
                    $display("[TB] FAIL burst_bytecnt c=%0d: got %0d expected %0d", c, reg_bytecnt, c - 1);
                end
            end
            vectors++;
            if (write_data !== exp_wd) begin
                miscompares++;
                $display("[TB] FAIL burst_wdata c=%0d: got %h expected %h", c, write_data, exp_wd);
            end
            vectors++;
            if (m1_rdata !== exp_rd || m0_read_data !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL burst_rdata c=%0d: got m1 %h m0 %h expected m1 %h m0 00", c, m1_rdata, m0_read_data, exp_rd);
            end
            if (m1_wpop === 1'b1) popped++;
        end
        tick();
        sample();
        vectors++;
        if (bus_flags() !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL burst_after_done: got %h expected 00", bus_flags());
        end
    endtask

    task automatic test_m1_write();
        test_burst(8'h0E, 8, 1'b0, 1'b1, 8'h10);
    endtask

    task automatic test_m1_read();
        test_burst(8'h00, 8, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_random_bursts();
        for (int n = 0; n < 8; n++) begin
            test_burst(8'($urandom), int'($urandom_range(1, 12)), 1'($urandom), 1'b0, 8'h00);
        end
    endtask

    task automatic test_zero_length();
        test_burst(8'($urandom), 0, 1'b0, 1'b0, 8'h00);
        test_burst(8'($urandom), 0, 1'b1, 1'b0, 8'h00);
    endtask

    // ------------------------------------------------------------------
    // M0 and M1 request in the same IDLE cycle; M0 holds for h cycles.
    task automatic test_simultaneous(input int h);
        logic [7:0]    ma, a1, wd;
        logic [BW-1:0] mb;
        logic [7:0]    exp_flags, exp_addr;
        ma = 8'($urandom); a1 = 8'($urandom); wd = 8'($urandom); mb = BW'($urandom);
        tick();
        m0_addrvalid = 1'b1;
        m0_address   = ma;
        m1_req       = 1'b1;
        m1_address   = a1;
        m1_len       = '0;
        m1_rnw       = 1'b0;
        sample();
        vectors++;
        if (bus_flags() !== 8'b0100_0000 || reg_address !== ma) begin
            miscompares++;
            $display("[TB] FAIL simul_first: got %h/%h expected 40/%h", bus_flags(), reg_address, ma);
        end
        for (int c = 1; c <= h + 6; c++) begin
            tick();
            m0_write      = (c == 1);
            m0_write_data = (c == 1) ? wd : 8'h00;
            m0_bytecnt    = (c == 1) ? mb : '0;
            if (c == h) begin
                m0_addrvalid = 1'b0;
                m0_address   = 8'h00;
            end
            if (c == h + 3) m1_req = 1'b0;
            sample();
            exp_addr = 8'h00;
            if (c < h) begin
                exp_flags = {1'b0, 1'b1, 1'b0, (c == 1), 4'b0000};
                exp_addr  = ma;
            end else if (c == h + 3 || c == h + 4) begin
                exp_flags = 8'b1100_0000;
                exp_addr  = a1;
            end else if (c == h + 5) begin
                exp_flags = 8'b0000_0100;
            end else begin
                exp_flags = 8'h00;
            end
            vectors++;
            if (bus_flags() !== exp_flags || reg_address !== exp_addr) begin
                miscompares++;
                $display("[TB] FAIL simul c=%0d h=%0d: got %h/%h expected %h/%h", c, h, bus_flags(), reg_address, exp_flags, exp_addr);
            end
            if (c == 1) begin
                vectors++;
                if (write_data !== wd || reg_bytecnt !== mb) begin
                    miscompares++;
                    $display("[TB] FAIL simul_m0_write: got %h/%h expected %h/%h", write_data, reg_bytecnt, wd, mb);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // M1 read burst of 8 preempted by M0 during transfer byte k.
    task automatic test_preempt(input int k);
        logic [7:0]    addr, ma;
        logic [BW-1:0] mb;
        logic [7:0]    exp_flags, exp_addr, exp_m1, exp_m0;
        addr = 8'($urandom); ma = 8'($urandom); mb = BW'($urandom);
        tick();
        m1_req = 1'b1; m1_address = addr; m1_len = BW'(8); m1_rnw = 1'b1;
        sample();
        vectors++;
        if (bus_flags() !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL preempt_req_cycle: got %h expected 00", bus_flags());
        end
        for (int c = 0; c <= k + 5; c++) begin
            tick();
            m1_req = 1'b0;
            if (c == k + 1) begin
                m0_addrvalid = 1'b1; m0_address = ma; m0_bytecnt = mb;
            end
            m0_read = (c == k + 2);
            if (c == k + 4) begin
                m0_addrvalid = 1'b0; m0_address = 8'h00; m0_bytecnt = '0;
            end
            sample();
            exp_m1 = 8'h00; exp_m0 = 8'h00; exp_addr = 8'h00;
            if (c == 0) begin
                exp_flags = 8'b1100_0000; exp_addr = addr;
            end else if (c <= k + 1) begin
                exp_flags = {5'b11100, 2'b00, (c >= 2)};
                exp_addr  = addr;
                if (c >= 2) exp_m1 = reg_value(addr, BW'(c - 2));
            end else if (c == k + 2) begin
                exp_flags = 8'b0110_0011; exp_addr = ma;
                exp_m1    = reg_value(addr, BW'(k));
            end else if (c == k + 3) begin
                exp_flags = 8'b0100_0000; exp_addr = ma;
                exp_m0    = reg_value(ma, mb);
            end else begin
                exp_flags = 8'h00;
            end
            vectors++;
            if (bus_flags() !== exp_flags || reg_address !== exp_addr) begin
                miscompares++;
                $display("[TB] FAIL preempt c=%0d k=%0d: got %h/%h expected %h/%h", c, k, bus_flags(), reg_address, exp_flags, exp_addr);
            end
            vectors++;
            if (m1_rdata !== exp_m1 || m0_read_data !== exp_m0) begin
                miscompares++;
                $display("[TB] FAIL preempt_rdata c=%0d k=%0d: got m1 %h m0 %h expected m1 %h m0 %h", c, k, m1_rdata, m0_read_data, exp_m1, exp_m0);
            end
            if (c >= 1 && c <= k + 1) begin
                vectors++;
                if (reg_bytecnt !== BW'(c - 1)) begin
                    miscompares++;
                    $display("[TB] FAIL preempt_bytecnt c=%0d: got %0d expected %0d", c, reg_bytecnt, c - 1);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midburst();
        tick();
        m1_req = 1'b1; m1_address = 8'($urandom); m1_len = BW'(8); m1_rnw = 1'b0;
        m1_wdata = 8'($urandom);
        sample();
        repeat (4) begin
            tick();
            m1_req = 1'b0;
            sample();
        end
        vectors++;
        if (bus_flags() !== 8'b1101_1000) begin
            miscompares++;
            $display("[TB] FAIL midburst_xfer: got %h expected d8", bus_flags());
        end
        tick();
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus_flags() !== 8'h00 || {reg_address, reg_bytecnt, write_data} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midburst_reset_now: got %h/%h/%h expected zero", bus_flags(), reg_address, write_data);
        end
        sample();
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sample();
            vectors++;
            if (bus_flags() !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL midburst_after c=%0d: got %h expected 00", c, bus_flags());
            end
            tick();
        end
    endtask

`ifdef TRACE_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------
    // M0 holds the bus for 20 cycles while M1 requests; threshold is 16.
    task automatic test_timeout();
        tick();
        reset_n = 1'b0;
        idle_inputs();
        tick();
        reset_n = 1'b1;
        sample();
        vectors++;
        if (O_m1_starved !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL starved_after_reset: got %b expected 0", O_m1_starved);
        end
        for (int n = 0; n < 24; n++) begin
            tick();
            m0_addrvalid = (n < 20);
            m0_address   = (n < 20) ? 8'h5A : 8'h00;
            m1_req       = (n < 23);
            m1_len       = '0;
            sample();
            vectors++;
            if (O_m1_starved !== (n >= 16)) begin
                miscompares++;
                $display("[TB] FAIL starved n=%0d: got %b expected %b", n, O_m1_starved, (n >= 16));
            end
            if (n == 23) begin
                vectors++;
                if (m1_gnt !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL starved_grant: got %b expected 1", m1_gnt);
                end
            end
        end
        repeat (4) tick();
        sample();
        vectors++;
        if (O_m1_starved !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL starved_sticky: got %b expected 1", O_m1_starved);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        salt        = 8'h41;
        reset_n     = 1'b0;
        idle_inputs();
        $display("[TB] starting trace_reg_arbiter bench");
        test_reset();
        test_m1_write();
        test_m1_read();
        salt = 8'($urandom);
        test_random_bursts();
        test_zero_length();
        for (int n = 0; n < 3; n++) test_simultaneous(int'($urandom_range(2, 5)));
        test_preempt(3);
        for (int n = 0; n < 4; n++) test_preempt(int'($urandom_range(0, 6)));
        test_reset_midburst();
`ifdef TRACE_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
